// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter controller.
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/Adder.sv
// Plain 32-bit adder; wraps modulo 2^32.
module Adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_controller.sv
// Fetch PC sequencer with boot, stall and one-slot redirect handling.
// Optional redirect counter output is built when PC_REDIRECT_COUNT_EN is defined.
module pc_controller
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    output logic [31:0] PCResult,
    output logic [31:0] PCAddResult,
    output logic        InstrValid,
    output logic        Flush
`ifdef PC_REDIRECT_COUNT_EN
    ,
    output logic [15:0] RedirectCount
`endif
);

    pc_state_t   state_r;
    logic [31:0] pc_r;
    logic        instr_valid_r;
    logic        flush_r;
    logic [31:0] pc_add4_s;
    logic [31:0] branch_bytes_s;
    logic [31:0] branch_target_s;
    logic [31:0] jump_target_s;

    assign branch_bytes_s = BranchOffset << 2;
    // Jump keeps the region nibble of the sequential address, not of the current PC.
    assign jump_target_s  = {pc_add4_s[31:28], JumpTarget, 2'b00};

    Adder u_pc_add4 (
        .a   (pc_r),
        .b   (PC_INCR),
        .sum (pc_add4_s)
    );

    Adder u_branch_add (
        .a   (pc_add4_s),
        .b   (branch_bytes_s),
        .sum (branch_target_s)
    );

    assign PCResult    = pc_r;
    assign PCAddResult = pc_add4_s;
    assign InstrValid  = instr_valid_r;
    assign Flush       = flush_r;

    // Sequencer: PC, state and the state-decoded valid/flush flops update together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_r          <= RESET_PC;
            state_r       <= BOOT;
            instr_valid_r <= 1'b0;
            flush_r       <= 1'b0;
        end else begin
            case (state_r)
                BOOT: begin
                    state_r       <= RUN;
                    instr_valid_r <= 1'b1;
                    flush_r       <= 1'b0;
                end
                RUN: begin
                    if (Jump) begin
                        pc_r          <= jump_target_s;
                        state_r       <= REDIRECT;
                        instr_valid_r <= 1'b1;
                        flush_r       <= 1'b1;
                    end else if (BranchTaken) begin
                        pc_r          <= branch_target_s;
                        state_r       <= REDIRECT;
                        instr_valid_r <= 1'b1;
                        flush_r       <= 1'b1;
                    end else if (Stall) begin
                        state_r       <= STALL;
                        instr_valid_r <= 1'b0;
                        flush_r       <= 1'b0;
                    end else begin
                        pc_r          <= pc_add4_s;
                        state_r       <= RUN;
                        instr_valid_r <= 1'b1;
                        flush_r       <= 1'b0;
                    end
                end
                STALL: begin
                    // Leaving STALL refetches the held PC rather than advancing it.
                    if (Stall) begin
                        state_r       <= STALL;
                        instr_valid_r <= 1'b0;
                    end else begin
                        state_r       <= RUN;
                        instr_valid_r <= 1'b1;
                    end
                    flush_r <= 1'b0;
                end
                REDIRECT: begin
                    if (Stall) begin
                        state_r       <= STALL;
                        instr_valid_r <= 1'b0;
                    end else begin
                        pc_r          <= pc_add4_s;
                        state_r       <= RUN;
                        instr_valid_r <= 1'b1;
                    end
                    flush_r <= 1'b0;
                end
                default: begin
                    state_r       <= BOOT;
                    instr_valid_r <= 1'b0;
                    flush_r       <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_REDIRECT_COUNT_EN
    logic        redirect_entry_s;
    logic [15:0] redirect_count_r;

    assign redirect_entry_s = (state_r == RUN) && (Jump || BranchTaken);
    assign RedirectCount    = redirect_count_r;

    // Count every entry into the redirect slot; wraps naturally at 16 bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            redirect_count_r <= 16'd0;
        end else if (redirect_entry_s) begin
            redirect_count_r <= redirect_count_r + 16'd1;
        end else begin
            redirect_count_r <= redirect_count_r;
        end
    end
`endif

endmodule

// File: tb/tb_pc_controller.sv
// Directed bench for pc_controller with a per-cycle reference model and literal pins.
module tb_pc_controller;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpTarget;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        InstrValid;
    logic        Flush;
`ifdef PC_REDIRECT_COUNT_EN
    logic [15:0] RedirectCount;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: expected observable outputs, advanced each rising edge.
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_flush;
    bit          m_boot;
    bit          m_known = 1'b0;
    logic [15:0] m_cnt;

    pc_controller #(.RESET_PC(32'h0000_0000)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchOffset (BranchOffset),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .PCResult     (PCResult),
        .PCAddResult  (PCAddResult),
        .InstrValid   (InstrValid),
        .Flush        (Flush)
`ifdef PC_REDIRECT_COUNT_EN
        ,
        .RedirectCount(RedirectCount)
`endif
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model rules written in terms of what a fetch stream looks like, not state codes.
    always @(posedge Clk) begin
        if (Reset) begin
            m_pc = 32'h0; m_valid = 1'b0; m_flush = 1'b0; m_boot = 1'b1;
            m_known = 1'b1; m_cnt = 16'd0;
        end else if (m_known) begin
            if (m_boot) begin
                m_boot = 1'b0; m_valid = 1'b1;
            end else if (!m_valid) begin
                if (!Stall) m_valid = 1'b1;
            end else if (m_flush) begin
                m_flush = 1'b0;
                if (Stall) m_valid = 1'b0;
                else m_pc = m_pc + 32'd4;
            end else if (Jump) begin
                m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(JumpTarget) * 32'd4);
                m_flush = 1'b1; m_cnt = m_cnt + 16'd1;
            end else if (BranchTaken) begin
                m_pc = m_pc + 32'd4 + BranchOffset * 32'd4;
                m_flush = 1'b1; m_cnt = m_cnt + 16'd1;
            end else if (Stall) begin
                m_valid = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    // Single compare process: every cycle once the model is anchored by reset.
    always @(negedge Clk) begin
        if (m_known) begin
            chk("pc",      PCResult,    m_pc);
            chk("pc_add4", PCAddResult, m_pc + 32'd4);
            chk("valid",   {31'd0, InstrValid}, {31'd0, m_valid});
            chk("flush",   {31'd0, Flush},      {31'd0, m_flush});
`ifdef PC_REDIRECT_COUNT_EN
            chk("rcount",  {16'd0, RedirectCount}, {16'd0, m_cnt});
`endif
        end
    end

    // Apply one cycle of inputs at the falling edge, return at the next falling edge.
    task automatic cyc(input bit rst, input bit s, input bit b, input logic [31:0] off,
                       input bit j, input logic [25:0] jt);
        Reset = rst; Stall = s; BranchTaken = b; BranchOffset = off; Jump = j; JumpTarget = jt;
        @(negedge Clk);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchOffset = 32'd0;
        Jump = 1'b0; JumpTarget = 26'd0;
        @(negedge Clk);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3F);
        chk("lit_reset_pc", PCResult, 32'h0);
        chk("lit_boot_valid", {31'd0, InstrValid}, 32'd0);
        idle(); chk("lit_first_pc", PCResult, 32'h0);
        chk("lit_first_valid", {31'd0, InstrValid}, 32'd1);
        idle(); chk("lit_pc4", PCResult, 32'h4);
        idle(); chk("lit_pc8", PCResult, 32'h8);

        // Backward branch from 0x100
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h3F); chk("lit_jump_fc", PCResult, 32'hFC);
        idle(); chk("lit_run_100", PCResult, 32'h100);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
        chk("lit_branch_back", PCResult, 32'hFC);
        chk("lit_branch_flush", {31'd0, Flush}, 32'd1);
        idle(); chk("lit_after_redirect", PCResult, 32'h100);
        chk("lit_flush_one_cycle", {31'd0, Flush}, 32'd0);

        // Jump beats branch in region 0x3
        cyc(1'b0, 1'b0, 1'b1, 32'h0BFF_FFC2, 1'b0, 26'd0);
        idle(); chk("lit_region3", PCResult, 32'h3000_0010);
        cyc(1'b0, 1'b0, 1'b1, 32'd5, 1'b1, 26'h40);
        chk("lit_jump_priority", PCResult, 32'h3000_0100);
        idle();

        // Wrap at top of address space; branch in redirect slot ignored
        cyc(1'b0, 1'b0, 1'b1, 32'h33FF_FFBC, 1'b0, 26'd0);
        chk("lit_near_top", PCResult, 32'hFFFF_FFF8);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 26'd0);
        chk("lit_slot_ignored", PCResult, 32'hFFFF_FFFC);
        idle(); chk("lit_wrap_zero", PCResult, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0);
        chk("lit_back_wrap", PCResult, 32'hFFFF_FFFC);
        idle();

        // Three-cycle stall at 0x20, jump ignored while stalled
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'd7);
        idle(); chk("lit_at_20", PCResult, 32'h20);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'd9, 1'b0, 26'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h99);
        chk("lit_stall_hold", PCResult, 32'h20);
        chk("lit_stall_invalid", {31'd0, InstrValid}, 32'd0);
        idle(); chk("lit_resume_20", PCResult, 32'h20);
        chk("lit_resume_valid", {31'd0, InstrValid}, 32'd1);
        idle(); chk("lit_resume_24", PCResult, 32'h24);

        // Redirect followed by stall, then resume
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 26'h10);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
        chk("lit_redirect_stall", PCResult, 32'h40);
        idle(); idle(); chk("lit_after_stall", PCResult, 32'h44);

        // Reset discards a pending redirect and a pending stall
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h20);
        cyc(1'b1, 1'b1, 1'b1, 32'd3, 1'b1, 26'h5);
        chk("lit_reset_mid_redirect", PCResult, 32'h0);
        idle(); idle();
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
        chk("lit_boot_ignores_stall", {31'd0, InstrValid}, 32'd1);
        idle();

`ifdef PC_REDIRECT_COUNT_EN
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
        idle(); idle();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 26'd0);
            idle();
        end
        chk("lit_rcount_3", {16'd0, RedirectCount}, 32'd3);
        cyc(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0);
        chk("lit_rcount_0", {16'd0, RedirectCount}, 32'd0);
        idle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
